// File: rtl/mim_mem_pkg.sv
// Shared definitions for the memory access unit and the memory it drives:
// FSM state encoding, channel identifiers and default port widths.
package mim_mem_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  // Channel identifiers, also used as the encoding of last_grant.
  localparam logic CH_FETCH = 1'b0;
  localparam logic CH_DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-way alternating-priority arbiter for the fetch and data channels.
// Grants are purely combinational and at most one is high at a time.
module mem_arbiter
  import mim_mem_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic enable,
  input  logic last_grant,
  output logic if_gnt,
  output logic d_gnt
);

  // Data wins a tie unless it also won the previous grant.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (enable) begin
      if (d_req && (!if_req || (last_grant == CH_FETCH))) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the single-port word memory. Arbitrates fetch and data
// requests, runs one memory access at a time and returns one response pulse
// per accepted request on the owning channel.
module mem_access_unit
  import mim_mem_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int READ_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Value of the wait counter on the final RD cycle (READ_WAIT is 0..3).
  localparam logic [1:0] WAIT_LAST = 2'(READ_WAIT);

  state_t            state_reg;
  state_t            state_next;
  logic              ch_reg;
  logic              last_grant_reg;
  logic [1:0]        wait_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] d_rdata_reg;
  logic              arb_enable;
  logic              rd_last;

  // Grants only in IDLE, and never while reset is being applied.
  assign arb_enable = (state_reg == IDLE) && !rst;
  assign rd_last    = (wait_cnt_reg == WAIT_LAST);

  mem_arbiter u_arbiter (
    .if_req     (if_req),
    .d_req      (d_req),
    .enable     (arb_enable),
    .last_grant (last_grant_reg),
    .if_gnt     (if_gnt),
    .d_gnt      (d_gnt)
  );

  // Next-state and memory/response strobes decoded from the current state.
  always_comb begin
    state_next = state_reg;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if_rvalid  = 1'b0;
    d_rvalid   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (d_gnt) begin
          state_next = d_we ? WR : RD;
        end else if (if_gnt) begin
          state_next = RD;
        end
      end
      RD: begin
        mem_read = 1'b1;
        if (rd_last) begin
          state_next = RESP;
        end
      end
      WR: begin
        mem_write  = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        // A transaction cut short by reset must not produce a response.
        if_rvalid  = !rst && (ch_reg == CH_FETCH);
        d_rvalid   = !rst && (ch_reg == CH_DATA);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the granted request; this also remembers who won for alternation.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg       <= '0;
      wdata_reg      <= '0;
      ch_reg         <= CH_FETCH;
      last_grant_reg <= CH_FETCH;
    end else if (d_gnt) begin
      addr_reg       <= d_addr;
      wdata_reg      <= d_wdata;
      ch_reg         <= CH_DATA;
      last_grant_reg <= CH_DATA;
    end else if (if_gnt) begin
      addr_reg       <= if_addr;
      ch_reg         <= CH_FETCH;
      last_grant_reg <= CH_FETCH;
    end
  end

  // Count RD cycles so mem_read stays high for READ_WAIT+1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= 2'd0;
    end else if ((state_reg == RD) && !rd_last) begin
      wait_cnt_reg <= wait_cnt_reg + 2'd1;
    end else begin
      wait_cnt_reg <= 2'd0;
    end
  end

  // Sample memory data on the last RD cycle into the owning channel only.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else if ((state_reg == RD) && rd_last) begin
      if (ch_reg == CH_FETCH) begin
        if_rdata_reg <= mem_rdata;
      end else begin
        d_rdata_reg <= mem_rdata;
      end
    end
  end

  assign mem_address    = addr_reg;
  assign mem_write_data = wdata_reg;
  assign if_rdata       = if_rdata_reg;
  assign d_rdata        = d_rdata_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (READ_WAIT=0 and READ_WAIT=2),
// each with its own behavioural memory and a scoreboard of expected responses.
`timescale 1ns/1ps
module tb_mem_access_unit;

  typedef struct packed {
    logic        is_d;
    logic        is_st;
    logic [15:0] data;
    logic [31:0] due;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst            [2];
  logic        if_req         [2];
  logic [9:0]  if_addr        [2];
  logic        if_gnt         [2];
  logic        if_rvalid      [2];
  logic [15:0] if_rdata       [2];
  logic        d_req          [2];
  logic        d_we           [2];
  logic [9:0]  d_addr         [2];
  logic [15:0] d_wdata        [2];
  logic        d_gnt          [2];
  logic        d_rvalid       [2];
  logic [15:0] d_rdata        [2];
  logic [9:0]  mem_address    [2];
  logic [15:0] mem_write_data [2];
  logic        mem_read       [2];
  logic        mem_write      [2];
  logic [15:0] mem_rdata      [2];
  logic        busy           [2];
  logic        preload;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] pat(input int inst, input int a);
    if (a == 3) return 16'h8080;
    return 16'(a * 257) ^ 16'hA5C3 ^ 16'(inst);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int RW = gi * 2;
    logic [15:0] mem     [1024];
    logic [15:0] ref_mem [1024];
    sb_t         sb_q[$];
    int          free_at;
    int          rd_cnt;
    int          wr_cnt;
    logic        lg;
    logic [15:0] last_if;
    logic [15:0] last_d;
    logic [9:0]  cur_addr;
    logic [15:0] cur_wdata;

    mem_access_unit #(.ADDR_W(10), .DATA_W(16), .READ_WAIT(RW)) u_dut (
      .clk            (clk),
      .rst            (rst[gi]),
      .if_req         (if_req[gi]),
      .if_addr        (if_addr[gi]),
      .if_gnt         (if_gnt[gi]),
      .if_rvalid      (if_rvalid[gi]),
      .if_rdata       (if_rdata[gi]),
      .d_req          (d_req[gi]),
      .d_we           (d_we[gi]),
      .d_addr         (d_addr[gi]),
      .d_wdata        (d_wdata[gi]),
      .d_gnt          (d_gnt[gi]),
      .d_rvalid       (d_rvalid[gi]),
      .d_rdata        (d_rdata[gi]),
      .mem_address    (mem_address[gi]),
      .mem_write_data (mem_write_data[gi]),
      .mem_read       (mem_read[gi]),
      .mem_write      (mem_write[gi]),
      .mem_rdata      (mem_rdata[gi]),
      .busy           (busy[gi])
    );

    // Memory: combinational read, write on rising clock.
    assign mem_rdata[gi] = mem[mem_address[gi]];
    always @(posedge clk) begin
      if (preload) begin
        for (int a = 0; a < 1024; a++) mem[a] <= pat(gi, a);
      end else if (mem_write[gi]) begin
        mem[mem_address[gi]] <= mem_write_data[gi];
      end
    end

    // Monitor: arbitration model, scoreboard push on grant, pop on response.
    always @(negedge clk) begin : mon
      logic       exp_any;
      logic       exp_d;
      logic [1:0] exp_g;
      sb_t        e;
      if (preload) begin
        for (int a = 0; a < 1024; a++) ref_mem[a] = pat(gi, a);
      end
      if (rst[gi]) begin
        sb_q.delete();
        free_at = cyc + 1;
        lg      = 1'b0;
        last_if = '0;
        last_d  = '0;
        rd_cnt  = 0;
        wr_cnt  = 0;
      end else begin
        exp_any = (if_req[gi] || d_req[gi]) && (cyc >= free_at);
        exp_d   = d_req[gi] && (!if_req[gi] || !lg);
        exp_g   = !exp_any ? 2'b00 : (exp_d ? 2'b01 : 2'b10);
        check($sformatf("grant%0d", gi), 32'({if_gnt[gi], d_gnt[gi]}), 32'(exp_g));
        check($sformatf("rw_excl%0d", gi), 32'(mem_read[gi] & mem_write[gi]), 32'd0);
        if (mem_read[gi]) begin
          rd_cnt++;
          check($sformatf("rd_addr%0d", gi), 32'(mem_address[gi]), 32'(cur_addr));
        end
        if (mem_write[gi]) begin
          wr_cnt++;
          check($sformatf("wr_addr%0d", gi), 32'(mem_address[gi]), 32'(cur_addr));
          check($sformatf("wr_data%0d", gi), 32'(mem_write_data[gi]), 32'(cur_wdata));
        end
        if (if_rvalid[gi] || d_rvalid[gi]) begin
          if (sb_q.size() == 0) begin
            check($sformatf("spurious_rvalid%0d", gi), 32'({if_rvalid[gi], d_rvalid[gi]}), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("resp_ch%0d", gi), 32'({if_rvalid[gi], d_rvalid[gi]}),
                  e.is_d ? 32'd1 : 32'd2);
            check($sformatf("resp_cycle%0d", gi), 32'(cyc), e.due);
            if (e.is_st) check($sformatf("wr_cycles%0d", gi), 32'(wr_cnt), 32'd1);
            else         check($sformatf("rd_cycles%0d", gi), 32'(rd_cnt), 32'(RW + 1));
            if (!e.is_d) last_if = e.data;
            else if (!e.is_st) last_d = e.data;
            $display("inst%0d resp %s data=%h cycle=%0d", gi,
                     e.is_st ? "store" : (e.is_d ? "load " : "fetch"), e.data, cyc);
          end
        end
        check($sformatf("if_rdata%0d", gi), 32'(if_rdata[gi]), 32'(last_if));
        check($sformatf("d_rdata%0d", gi), 32'(d_rdata[gi]), 32'(last_d));
        if (if_gnt[gi] || d_gnt[gi]) begin
          e.is_d    = d_gnt[gi];
          e.is_st   = d_gnt[gi] && d_we[gi];
          cur_addr  = d_gnt[gi] ? d_addr[gi] : if_addr[gi];
          cur_wdata = d_wdata[gi];
          if (e.is_st) begin
            ref_mem[cur_addr] = cur_wdata;
            e.data = cur_wdata;
          end else begin
            e.data = ref_mem[cur_addr];
          end
          e.due   = 32'(cyc + 2 + RW);
          free_at = cyc + 3 + RW;
          lg      = d_gnt[gi];
          rd_cnt  = 0;
          wr_cnt  = 0;
          sb_q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int i, input bit is_d, output int t);
    bit seen = 1'b0;
    t = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (is_d ? d_gnt[i] : if_gnt[i]) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    check("gnt_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_rvalid(input int i, input bit is_d);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (is_d ? d_rvalid[i] : if_rvalid[i]) seen = 1'b1;
    end
    check("rvalid_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   t0;
    int   t1;
    int   n_g;
    int   n_rv;
    logic prev_d;
    preload = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; if_req[i] = 1'b0; if_addr[i] = '0;
      d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
    end
    tick();
    tick();
    preload = 1'b0;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Reset state of both instances.
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_mem_read", 32'(mem_read[i]), 32'd0);
      check("rst_mem_write", 32'(mem_write[i]), 32'd0);
      check("rst_mem_address", 32'(mem_address[i]), 32'd0);
      check("rst_mem_wdata", 32'(mem_write_data[i]), 32'd0);
      check("rst_rvalid", 32'({if_rvalid[i], d_rvalid[i]}), 32'd0);
      check("rst_gnt", 32'({if_gnt[i], d_gnt[i]}), 32'd0);
    end

    // Fetch from address 3, READ_WAIT=0.
    if_addr[0] = 10'd3; if_req[0] = 1'b1;
    wait_gnt(0, 1'b0, t0);
    tick(); if_req[0] = 1'b0;
    check("f3_mem_read", 32'(mem_read[0]), 32'd1);
    check("f3_mem_address", 32'(mem_address[0]), 32'd3);
    tick();
    check("f3_rvalid", 32'(if_rvalid[0]), 32'd1);
    check("f3_rdata", 32'(if_rdata[0]), 32'h8080);
    tick();
    check("f3_busy", 32'(busy[0]), 32'd0);

    // Store 0xBEEF to 999, then load it back.
    d_addr[0] = 10'd999; d_wdata[0] = 16'hBEEF; d_we[0] = 1'b1; d_req[0] = 1'b1;
    wait_gnt(0, 1'b1, t0);
    tick(); d_req[0] = 1'b0;
    check("st_mem_write", 32'(mem_write[0]), 32'd1);
    check("st_mem_address", 32'(mem_address[0]), 32'd999);
    tick();
    check("st_mem_write_off", 32'(mem_write[0]), 32'd0);
    check("st_rvalid", 32'(d_rvalid[0]), 32'd1);
    check("st_keeps_d_rdata", 32'(d_rdata[0]), 32'd0);
    tick();
    d_we[0] = 1'b0; d_req[0] = 1'b1;
    wait_gnt(0, 1'b1, t0);
    tick(); d_req[0] = 1'b0;
    wait_rvalid(0, 1'b1);
    check("ld999_rdata", 32'(d_rdata[0]), 32'hBEEF);

    // Store immediately followed by a fetch of the same address.
    tick();
    d_addr[0] = 10'd500; d_wdata[0] = 16'h1357; d_we[0] = 1'b1; d_req[0] = 1'b1;
    wait_gnt(0, 1'b1, t0);
    tick(); d_req[0] = 1'b0; d_we[0] = 1'b0; if_addr[0] = 10'd500; if_req[0] = 1'b1;
    wait_gnt(0, 1'b0, t1);
    check("st_fetch_gap", 32'(t1 - t0), 32'd3);
    tick(); if_req[0] = 1'b0;
    wait_rvalid(0, 1'b0);
    check("st_fetch_rdata", 32'(if_rdata[0]), 32'h1357);

    // Both channels requesting continuously from reset: strict alternation.
    tick();
    rst[0] = 1'b1; if_req[0] = 1'b1; d_req[0] = 1'b1; d_we[0] = 1'b0;
    tick(); tick();
    rst[0] = 1'b0;
    n_g = 0;
    prev_d = 1'b0;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (if_gnt[0] || d_gnt[0]) begin
        check("alt_order", 32'(d_gnt[0]), 32'(!prev_d));
        prev_d = d_gnt[0];
        n_g++;
      end
      tick();
      if_addr[0] = 10'($urandom_range(0, 1023));
      d_addr[0]  = 10'($urandom_range(0, 1023));
      d_we[0]    = 1'($urandom_range(0, 1));
      d_wdata[0] = 16'($urandom);
    end
    check("alt_count", 32'(n_g), 32'd7);
    if_req[0] = 1'b0; d_req[0] = 1'b0; d_we[0] = 1'b0;
    repeat (6) tick();

    // READ_WAIT=2: load addr 10, fetch requested during RD.
    d_addr[1] = 10'd10; d_we[1] = 1'b0; d_req[1] = 1'b1;
    wait_gnt(1, 1'b1, t0);
    tick(); d_req[1] = 1'b0; if_addr[1] = 10'd20; if_req[1] = 1'b1;
    check("rw2_rd1", 32'(mem_read[1]), 32'd1);
    tick();
    check("rw2_rd2", 32'(mem_read[1]), 32'd1);
    tick();
    check("rw2_rd3", 32'(mem_read[1]), 32'd1);
    tick();
    check("rw2_rd_end", 32'(mem_read[1]), 32'd0);
    check("rw2_d_rvalid", 32'(d_rvalid[1]), 32'd1);
    check("rw2_d_rdata", 32'(d_rdata[1]), 32'(pat(1, 10)));
    wait_gnt(1, 1'b0, t1);
    check("rw2_fetch_gnt_gap", 32'(t1 - t0), 32'd5);
    tick(); if_req[1] = 1'b0;
    wait_rvalid(1, 1'b0);
    check("rw2_if_rdata", 32'(if_rdata[1]), 32'(pat(1, 20)));

    // Reset during RD of a fetch drops the transaction.
    tick();
    if_addr[1] = 10'd7; if_req[1] = 1'b1;
    wait_gnt(1, 1'b0, t0);
    tick(); if_req[1] = 1'b0; rst[1] = 1'b1;
    check("rstrd_in_rd", 32'(mem_read[1]), 32'd1);
    tick(); rst[1] = 1'b0;
    check("rstrd_busy", 32'(busy[1]), 32'd0);
    check("rstrd_mem_read", 32'(mem_read[1]), 32'd0);
    check("rstrd_if_rdata", 32'(if_rdata[1]), 32'd0);
    check("rstrd_d_rdata", 32'(d_rdata[1]), 32'd0);
    check("rstrd_mem_address", 32'(mem_address[1]), 32'd0);
    n_rv = 0;
    for (int k = 0; k < 8; k++) begin
      if (if_rvalid[1]) n_rv++;
      tick();
    end
    check("rstrd_no_rvalid", 32'(n_rv), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
